// File: rtl/sar_adc_ctrl_if.sv
// ============================================================================
//  Module      : sar_adc_ctrl_if
//  Description : Handshake and front-end bundle for the SAR ADC controller.
//                slave  : converter side (sar_adc_ctrl)
//                master : acquisition sequencer / analog front end side
//  Signals     : soc         start of conversion (sequencer -> converter)
//                cmp         comparator decision, 1 = Vin >= Vdac
//                sample_hold S/H tracking enable
//                dac_code    trial code for the DAC
//                data        last completed conversion result
//                busy        conversion in progress
//                eoc         end of conversion (level)
//                ovr         soc arrived while busy (one-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             soc;
  logic             cmp;
  logic             sample_hold;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             eoc;
  logic             ovr;

  modport slave (
    input  soc, cmp,
    output sample_hold, dac_code, data, busy, eoc, ovr
  );

  modport master (
    output soc, cmp,
    input  sample_hold, dac_code, data, busy, eoc, ovr
  );
endinterface

`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
// ============================================================================
//  Module      : sar_adc_ctrl
//  Description : Successive-approximation ADC controller. On soc it holds
//                sample_hold high for SAMPLE_CYCLES clocks, then performs a
//                WIDTH-step binary search against the external comparator
//                and presents the result on data with eoc held high.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous reset, active-high
//                bus  - sar_adc_ctrl_if.slave (soc, cmp in; sample_hold,
//                       dac_code, data, busy, eoc, ovr out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sar_adc_ctrl_if.slave bus
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_sample  = 2'd1;
  localparam logic [1:0] c_st_convert = 2'd2;
  localparam logic [1:0] c_st_done    = 2'd3;

  localparam int                  c_cnt_w    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(SAMPLE_CYCLES - 1);
  localparam logic [WIDTH-1:0]    c_msb      = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_trial;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_result_upd;
  logic               r_ovr;
  logic               w_busy;

  assign w_busy       = (r_state == c_st_sample) || (r_state == c_st_convert);
  // Keep the trial bit only if the input is at or above the trial level.
  assign w_result_upd = bus.cmp ? (r_result | r_trial) : r_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: if (bus.soc) w_state_nxt = c_st_sample;
      c_st_sample:          if (r_cnt == c_cnt_last) w_state_nxt = c_st_convert;
      c_st_convert:         if (r_trial[0]) w_state_nxt = c_st_done;
      default:              w_state_nxt = c_st_idle;
    endcase
  end

  // Sample counter, search registers, result latch and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_trial  <= '0;
      r_result <= '0;
      r_data   <= '0;
      r_ovr    <= 1'b0;
    end else begin
      // soc during a conversion is dropped; only the flag records it.
      r_ovr <= w_busy & bus.soc;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (bus.soc) r_cnt <= '0;
        end
        c_st_sample: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_trial  <= c_msb;
            r_result <= '0;
          end
        end
        c_st_convert: begin
          r_result <= w_result_upd;
          r_trial  <= r_trial >> 1;
          // Trial on bit 0 is the last step: publish the finished code.
          if (r_trial[0]) r_data <= w_result_upd;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.sample_hold = 1'b0;
    bus.busy        = 1'b0;
    bus.eoc         = 1'b0;
    bus.dac_code    = '0;
    case (r_state)
      c_st_sample: begin
        bus.sample_hold = 1'b1;
        bus.busy        = 1'b1;
      end
      c_st_convert: begin
        bus.busy     = 1'b1;
        bus.dac_code = r_result | r_trial;
      end
      c_st_done: begin
        bus.eoc      = 1'b1;
        bus.dac_code = r_result;
      end
      default: ;
    endcase
  end

  assign bus.data = r_data;
  assign bus.ovr  = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// ============================================================================
//  Module      : tb_sar_adc_ctrl
//  Description : Self-checking bench for sar_adc_ctrl. An ideal comparator
//                (cmp = vin >= dac_code) closes the loop; expected trial
//                codes come from a plain binary-search model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_adc_ctrl;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_data;
    int         ovr_at;     // negedge index (after soc edge) to pulse soc; -1 = none
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vin_a;
  logic [3:0] vin_b;

  int tests = 0;
  int fails = 0;

  int exp_trials[$];
  int exp_code;

  sar_adc_ctrl_if #(.WIDTH(8)) if_a ();
  sar_adc_ctrl_if #(.WIDTH(4)) if_b ();

  assign if_a.cmp = (vin_a >= if_a.dac_code);
  assign if_b.cmp = (vin_b >= if_b.dac_code);

  sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Binary search: each step tries the current code plus the next lower
  // power of two and keeps it if the input reaches that level.
  function automatic void model_search(input int v, input int w);
    int code;
    int t;
    exp_trials.delete();
    code = 0;
    for (int b = w - 1; b >= 0; b--) begin
      t = code + (1 << b);
      exp_trials.push_back(t);
      if (v >= t) code = t;
    end
    exp_code = code;
  endfunction

  task automatic convert_a(input logic [7:0] v, input logic [7:0] exp, input int ovr_at);
    int         n;
    int         sh;
    int         ovr_cnt;
    int         ovr_pos;
    int         data_chg;
    int         got[$];
    logic [7:0] d_prev;
    model_search(int'(v), 8);
    check("model_code", exp_code, int'(exp));
    @(negedge clk);
    vin_a = v;
    if_a.soc = 1'b1;
    d_prev = if_a.data;
    @(negedge clk);
    if_a.soc = 1'b0;
    n = 0; sh = 0; ovr_cnt = 0; ovr_pos = -1; data_chg = 0;
    check("eoc_drop", int'(if_a.eoc), 0);
    while (!if_a.eoc && n < 40) begin
      if (if_a.sample_hold) sh++;
      if (if_a.busy && !if_a.sample_hold) got.push_back(int'(if_a.dac_code));
      if (if_a.ovr) begin ovr_cnt++; ovr_pos = n; end
      if (if_a.data != d_prev) data_chg++;
      if (n == ovr_at) if_a.soc = 1'b1;
      if (n == ovr_at + 1) if_a.soc = 1'b0;
      @(negedge clk);
      n++;
    end
    check("latency", n, 10);
    check("sample_hold_cycles", sh, 2);
    check("data_early_change", data_chg, 0);
    check("trial_count", got.size(), exp_trials.size());
    for (int i = 0; i < got.size() && i < exp_trials.size(); i++)
      check($sformatf("trial_%0d", i), got[i], exp_trials[i]);
    check("data", int'(if_a.data), int'(exp));
    check("dac_done", int'(if_a.dac_code), int'(exp));
    check("ovr_count", ovr_cnt, (ovr_at >= 0) ? 1 : 0);
    if (ovr_at >= 0) check("ovr_pos", ovr_pos, ovr_at + 1);
    repeat (3) @(negedge clk);
    check("done_hold_eoc", int'(if_a.eoc), 1);
    check("done_hold_busy", int'(if_a.busy), 0);
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    int pos[$];
    int got[$];
    logic [7:0] rv;

    vecs[0] = '{vin: 8'hA5, exp_data: 8'hA5, ovr_at: -1};
    vecs[1] = '{vin: 8'h00, exp_data: 8'h00, ovr_at: -1};
    vecs[2] = '{vin: 8'hFF, exp_data: 8'hFF, ovr_at: -1};
    vecs[3] = '{vin: 8'h3C, exp_data: 8'h3C, ovr_at: 4};

    rst = 1'b1;
    if_a.soc = 1'b0; if_b.soc = 1'b0;
    vin_a = 8'h00; vin_b = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_sample_hold", int'(if_a.sample_hold), 0);
    check("rst_dac_code",    int'(if_a.dac_code), 0);
    check("rst_data",        int'(if_a.data), 0);
    check("rst_busy",        int'(if_a.busy), 0);
    check("rst_eoc",         int'(if_a.eoc), 0);
    check("rst_ovr",         int'(if_a.ovr), 0);
    check("rst_b_eoc",       int'(if_b.eoc), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(if_a.busy), 0);

    for (int i = 0; i < 4; i++)
      convert_a(vecs[i].vin, vecs[i].exp_data, vecs[i].ovr_at);

    // Asynchronous reset in the middle of the bit search.
    @(negedge clk);
    vin_a = 8'h6B;
    if_a.soc = 1'b1;
    @(negedge clk);
    if_a.soc = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", int'(if_a.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",     int'(if_a.busy), 0);
    check("arst_dac_code", int'(if_a.dac_code), 0);
    check("arst_data",     int'(if_a.data), 0);
    check("arst_eoc",      int'(if_a.eoc), 0);
    check("arst_sh",       int'(if_a.sample_hold), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle", int'(if_a.busy | if_a.eoc), 0);
    convert_a(8'h7F, 8'h7F, -1);

    // Randomized conversions, some with an overrun pulse inside the busy window.
    for (int i = 0; i < 12; i++) begin
      rv = 8'($urandom_range(0, 255));
      convert_a(rv, rv, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 8)));
    end

    // soc held high: back-to-back conversions with one DONE cycle between.
    @(negedge clk);
    vin_a = 8'h55;
    if_a.soc = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (if_a.eoc) begin
        pos.push_back(k);
        check("held_data", int'(if_a.data), 8'h55);
      end
    end
    if_a.soc = 1'b0;
    check("held_pulses", pos.size(), 2);
    for (int k = 0; k < pos.size(); k++)
      check($sformatf("held_pos_%0d", k), pos[k], (2 + 8) + k * (2 + 8 + 1));
    n = 0;
    while (!if_a.eoc && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_final_eoc", int'(if_a.eoc), 1);
    check("held_final_data", int'(if_a.data), 8'h55);

    // Narrow instance: WIDTH=4, SAMPLE_CYCLES=1.
    model_search(9, 4);
    @(negedge clk);
    vin_b = 4'h9;
    if_b.soc = 1'b1;
    @(negedge clk);
    if_b.soc = 1'b0;
    n = 0;
    while (!if_b.eoc && n < 20) begin
      if (if_b.busy && !if_b.sample_hold) got.push_back(int'(if_b.dac_code));
      @(negedge clk);
      n++;
    end
    check("w4_latency", n, 1 + 4);
    check("w4_trial_count", got.size(), exp_trials.size());
    for (int i = 0; i < got.size() && i < exp_trials.size(); i++)
      check($sformatf("w4_trial_%0d", i), got[i], exp_trials[i]);
    check("w4_data", int'(if_b.data), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
